param_univ_shift_reg: RTL and testbench
=======================================

PARAM_UNIV_SHIFT_REG -- requirements
Module: param_univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits (>=2).
REQ-002 Parameter CNT_W, default 4: width of the burst length field.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  mode enable; 0 = hold when idle.
REQ-006 mode  input  3  operation select (REQ-012).
REQ-007 serial_in_r  input  1  bit entering MSB on right shifts.
REQ-008 serial_in_l  input  1  bit entering LSB on left shifts.
REQ-009 parallel_in  input  WIDTH  parallel load data.
REQ-010 burst_start, burst_dir, burst_len  input  1/1/CNT_W  burst request, direction (0 right, 1 left), shift count.
REQ-011 q  output  WIDTH  register contents; serial_out_r output 1 = q[0]; serial_out_l output 1 = q[WIDTH-1]; busy output 1 = burst in progress; done output 1 = burst complete pulse.

Function
REQ-012 Idle, en=1, per edge, by mode: 000 hold; 001 shift right {serial_in_r,q[W-1:1]}; 010 shift left {q[W-2:0],serial_in_l}; 011 load parallel_in; 100 rotate right {q[0],q[W-1:1]}; 101 rotate left {q[W-2:0],q[W-1]}; 110 arithmetic right {q[W-1],q[W-1:1]}; 111 clear to 0.
REQ-013 Idle, en=0: q holds regardless of mode.
REQ-014 serial_out_r and serial_out_l are combinational from current q (pre-edge value is the bit shifted out).
REQ-015 FSM states IDLE and BURST; internal down-counter CNT_W bits.
REQ-016 IDLE, burst_start=1, burst_len!=0 at edge k: go BURST, counter<=burst_len, direction latched, q holds at edge k; burst_start beats mode/en.
REQ-017 burst_start=1 with burst_len=0: ignored; state stays IDLE; mode/en apply normally.
REQ-018 BURST: each edge shifts q one place in latched direction (right uses serial_in_r, left uses serial_in_l, sampled per edge), counter decrements.
REQ-019 Shift at which counter goes 1->0 is last; state returns IDLE on that edge; exactly burst_len shifts on edges k+1..k+burst_len.
REQ-020 busy = 1 exactly while state is BURST (burst_len cycles).
REQ-021 done = 1 for exactly the one cycle after the last burst edge; otherwise 0.
REQ-022 In BURST, en, mode, burst_start, burst_len, burst_dir ignored; new burst_start accepted only from IDLE (earliest the cycle done is high).

Reset
REQ-023 rst=0 at an edge: q<=0, state IDLE, counter<=0, busy=0, done=0; overrides all inputs.
REQ-024 Reset during BURST aborts it; no done pulse issued for the aborted burst.

Configuration
REQ-025 Macro PARAM_USR_BURST_EN: defined -> burst sequencer (REQ-015..022) built.
REQ-026 Not defined -> no FSM/counter; burst_start, burst_dir, burst_len ignored; busy and done tied 0; REQ-012/013 unchanged; ports kept.

Verification (WIDTH=8, CNT_W=4, macro defined unless stated)
REQ-027 rst=0 two edges with mode=011, en=1, parallel_in=8'hA5 -> q=8'h00, busy=0, done=0.
REQ-028 Load 8'hA5, then mode=001, serial_in_r=1 -> serial_out_r=1 before edge, q=8'hD2 after.
REQ-029 q=8'h81 mode=101 -> 8'h03; q=8'h80 mode=110 -> 8'hC0; q=8'h80 mode=100 -> 8'h40; en=0 mode=111 -> unchanged.
REQ-030 q=8'h0F, burst_start=1, len=3, dir=1, serial_in_l=0 -> q holds at accept edge, busy=1 three cycles, q=8'h78, done=1 one cycle; mode=111 during burst has no effect.
REQ-031 Burst len=5 on 8'hFF, rst=0 after second shift -> q=8'h00, busy=0, done never asserted; burst_start with len=0 -> busy stays 0.
REQ-032 Macro undefined: burst_start=1, len=3 -> busy=0, done=0, q follows mode/en only.

Source files
------------

// File: rtl/param_univ_shift_reg.sv
// Parameterized universal shift register with an optional burst sequencer.
// Define PARAM_USR_BURST_EN to build the burst FSM; without it, busy and done are tied low.
module param_univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             burst_start,
  input  logic             burst_dir,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHR   = 3'b001,
    M_SHL   = 3'b010,
    M_LOAD  = 3'b011,
    M_ROTR  = 3'b100,
    M_ROTL  = 3'b101,
    M_ASR   = 3'b110,
    M_CLEAR = 3'b111
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] mode_q;

  assign mode_sel     = mode_e'(mode);
  assign serial_out_r = q[0];
  assign serial_out_l = q[WIDTH-1];

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mode_q = q;
    case (mode_sel)
      M_HOLD:  mode_q = q;
      M_SHR:   mode_q = {serial_in_r, q[WIDTH-1:1]};
      M_SHL:   mode_q = {q[WIDTH-2:0], serial_in_l};
      M_LOAD:  mode_q = parallel_in;
      M_ROTR:  mode_q = {q[0], q[WIDTH-1:1]};
      M_ROTL:  mode_q = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ASR:   mode_q = {q[WIDTH-1], q[WIDTH-1:1]};
      M_CLEAR: mode_q = '0;
      default: mode_q = q;
    endcase
  end

`ifdef PARAM_USR_BURST_EN

  typedef enum logic {IDLE, BURST} state_e;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir, dir_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    q_nxt     = q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // A zero-length request is dropped so the mode logic still acts this edge.
        if (burst_start && burst_len != '0) begin
          state_nxt = BURST;
          cnt_nxt   = burst_len;
          dir_nxt   = burst_dir;
        end else if (en) begin
          q_nxt = mode_q;
        end
      end
      BURST: begin
        q_nxt   = dir ? {q[WIDTH-2:0], serial_in_l} : {serial_in_r, q[WIDTH-1:1]};
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
      q     <= q_nxt;
      done  <= done_nxt;
    end
  end

  assign busy = (state == BURST);

`else

  logic unused_burst;
  assign unused_burst = ^{burst_start, burst_dir, burst_len};

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= mode_q;
    end
  end

  assign busy = 1'b0;
  assign done = 1'b0;

`endif

endmodule

// File: tb/tb_param_univ_shift_reg.sv
// Scoreboard bench for param_univ_shift_reg: the driver queues hand-computed expectations,
// and a negedge monitor pops each one and compares it with the DUT outputs.
module tb_param_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic             serial_in_r;
  logic             serial_in_l;
  logic [WIDTH-1:0] parallel_in;
  logic             burst_start;
  logic             burst_dir;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] q;
  logic             serial_out_r;
  logic             serial_out_l;
  logic             busy;
  logic             done;

  param_univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .serial_in_r  (serial_in_r),
    .serial_in_l  (serial_in_l),
    .parallel_in  (parallel_in),
    .burst_start  (burst_start),
    .burst_dir    (burst_dir),
    .burst_len    (burst_len),
    .q            (q),
    .serial_out_r (serial_out_r),
    .serial_out_l (serial_out_l),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic [WIDTH-1:0] q;
    bit               busy;
    bit               done;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // The serial outputs must always mirror the end bits of the expected register value.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (q !== e.q || busy !== e.busy || done !== e.done ||
          serial_out_r !== e.q[0] || serial_out_l !== e.q[WIDTH-1]) begin
        failures++;
        $display("FAIL %s: got q=%02h busy=%b done=%b sor=%b sol=%b, want q=%02h busy=%b done=%b sor=%b sol=%b",
                 e.nm, q, busy, done, serial_out_r, serial_out_l,
                 e.q, e.busy, e.done, e.q[0], e.q[WIDTH-1]);
      end
    end
  end

  task automatic cyc(input string nm, input logic [WIDTH-1:0] eq, input bit eb, input bit ed);
    exp_t e;
    @(posedge clk);
    #1;
    e.nm   = nm;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; en = 1'b1; mode = 3'b011; parallel_in = 8'hA5;
    serial_in_r = 1'b0; serial_in_l = 1'b0;
    burst_start = 1'b0; burst_dir = 1'b0; burst_len = '0;

    cyc("rst_edge1", 8'h00, 0, 0);
    cyc("rst_edge2", 8'h00, 0, 0);

    rst = 1'b1;
    cyc("load_a5", 8'hA5, 0, 0);
    mode = 3'b001; serial_in_r = 1'b1;
    cyc("shr", 8'hD2, 0, 0);
    mode = 3'b011; parallel_in = 8'h81;
    cyc("load_81", 8'h81, 0, 0);
    mode = 3'b101;
    cyc("rotl", 8'h03, 0, 0);
    mode = 3'b011; parallel_in = 8'h80;
    cyc("load_80", 8'h80, 0, 0);
    mode = 3'b110;
    cyc("asr", 8'hC0, 0, 0);
    mode = 3'b011;
    cyc("load_80b", 8'h80, 0, 0);
    mode = 3'b100;
    cyc("rotr", 8'h40, 0, 0);
    en = 1'b0; mode = 3'b111;
    cyc("hold_en0", 8'h40, 0, 0);
    en = 1'b1; mode = 3'b010; serial_in_l = 1'b1;
    cyc("shl", 8'h81, 0, 0);
    mode = 3'b011; parallel_in = 8'h0F;
    cyc("load_0f", 8'h0F, 0, 0);

`ifdef PARAM_USR_BURST_EN
    burst_start = 1'b1; burst_len = 4'd3; burst_dir = 1'b1; serial_in_l = 1'b0; mode = 3'b111;
    cyc("bl_accept", 8'h0F, 1, 0);
    burst_start = 1'b0;
    cyc("bl_shift1", 8'h1E, 1, 0);
    burst_start = 1'b1; burst_len = 4'd7; burst_dir = 1'b0; serial_in_r = 1'b1;
    cyc("bl_shift2", 8'h3C, 1, 0);
    burst_start = 1'b0;
    cyc("bl_shift3", 8'h78, 0, 1);
    en = 1'b0;
    cyc("bl_after", 8'h78, 0, 0);

    en = 1'b1; mode = 3'b011; parallel_in = 8'h81;
    cyc("load_81b", 8'h81, 0, 0);
    burst_start = 1'b1; burst_len = 4'd2; burst_dir = 1'b0; serial_in_r = 1'b1;
    cyc("br_accept", 8'h81, 1, 0);
    burst_start = 1'b0;
    cyc("br_shift1", 8'hC0, 1, 0);
    serial_in_r = 1'b0;
    cyc("br_shift2", 8'h60, 0, 1);
    burst_start = 1'b1; burst_len = 4'd1; burst_dir = 1'b1; serial_in_l = 1'b1;
    cyc("b2b_accept", 8'h60, 1, 0);
    burst_start = 1'b0;
    cyc("b2b_shift1", 8'hC1, 0, 1);
    en = 1'b0;
    cyc("b2b_after", 8'hC1, 0, 0);

    en = 1'b1; mode = 3'b011; parallel_in = 8'hFF;
    cyc("load_ff", 8'hFF, 0, 0);
    burst_start = 1'b1; burst_len = 4'd5; burst_dir = 1'b0; serial_in_r = 1'b0;
    cyc("ab_accept", 8'hFF, 1, 0);
    burst_start = 1'b0;
    cyc("ab_shift1", 8'h7F, 1, 0);
    cyc("ab_shift2", 8'h3F, 1, 0);
    rst = 1'b0;
    cyc("ab_reset", 8'h00, 0, 0);
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ab_post", 8'h00, 0, 0);
`else
    burst_start = 1'b1; burst_len = 4'd3; burst_dir = 1'b1; mode = 3'b000;
    cyc("nb_hold", 8'h0F, 0, 0);
    mode = 3'b010; serial_in_l = 1'b0;
    cyc("nb_shl", 8'h1E, 0, 0);
    en = 1'b0; mode = 3'b111;
    cyc("nb_en0", 8'h1E, 0, 0);
    en = 1'b1;
    cyc("nb_clear", 8'h00, 0, 0);
`endif

    burst_start = 1'b1; burst_len = 4'd0; burst_dir = 1'b1;
    en = 1'b1; mode = 3'b011; parallel_in = 8'h5A;
    cyc("len0_load", 8'h5A, 0, 0);
    mode = 3'b000;
    cyc("len0_hold", 8'h5A, 0, 0);
    burst_start = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
